// File: rtl/cdb_pkg.sv
// cdb_pkg: shared CDB arbiter sizing constants and functional-unit requester indices.
package cdb_pkg;
  localparam int N_REQ  = 9;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int ADDR_W = 5;
  localparam int REQ_ALU1 = 0;
  localparam int REQ_ALU2 = 1;
  localparam int REQ_ALU3 = 2;
  localparam int REQ_MUL1 = 3;
  localparam int REQ_MUL2 = 4;
  localparam int REQ_DIV1 = 5;
  localparam int REQ_MEM1 = 6;
  localparam int REQ_MEM2 = 7;
  localparam int REQ_JUMP = 8;
endpackage

// File: rtl/cdb_rr_picker.sv
// cdb_rr_picker: one-hot grant of the first set request found searching upward from i_ptr (wrapping).
module cdb_rr_picker #(
  parameter int N  = 9,
  parameter int PW = 4
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);
  logic [N-1:0] w_rot, w_pick;
  // rotate so i_ptr lands on bit 0, isolate the lowest set bit, rotate back
  assign w_rot   = N'({i_req, i_req} >> i_ptr);
  assign w_pick  = w_rot & (-w_rot);
  assign o_grant = N'(({w_pick, w_pick} << i_ptr) >> N);
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result holding slots arbitrated onto one registered common data bus.
// Define CDB_RR_EN for round-robin grants; the default build uses fixed lowest-index priority.
module cdb_arbiter #(
  parameter int N_REQ  = cdb_pkg::N_REQ,
  parameter int DATA_W = cdb_pkg::DATA_W,
  parameter int TAG_W  = cdb_pkg::TAG_W,
  parameter int ADDR_W = cdb_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*TAG_W-1:0]   req_tag,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [ADDR_W-1:0]        cdb_addr,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [3:0]               pending_cnt
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0] w_valid, w_pick, w_grant, w_take;
  logic [N_REQ-1:0][TAG_W-1:0]  w_tag;
  logic [N_REQ-1:0][ADDR_W-1:0] w_addr;
  logic [N_REQ-1:0][DATA_W-1:0] w_data;
  logic [TAG_W-1:0]  w_sel_tag;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [PW-1:0]     w_ptr;

  cdb_rr_picker #(.N(N_REQ), .PW(PW)) u_pick (.i_req(w_valid), .i_ptr(w_ptr), .o_grant(w_pick));

  assign w_grant     = flush ? '0 : w_pick;
  assign req_ready   = ~w_valid | w_grant | {N_REQ{flush}};
  assign pending_cnt = 4'($countones(w_valid));

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    logic              r_v;
    logic [TAG_W-1:0]  r_t;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    // tag 0 marks "no result" and is never captured
    assign w_take[i] = req_valid[i] & req_ready[i] & (|req_tag[i*TAG_W +: TAG_W]) & ~flush;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_v <= 1'b0;
        r_t <= '0;
        r_a <= '0;
        r_d <= '0;
      end else if (flush) r_v <= 1'b0;
      else if (w_take[i]) begin
        r_v <= 1'b1;
        r_t <= req_tag[i*TAG_W +: TAG_W];
        r_a <= req_addr[i*ADDR_W +: ADDR_W];
        r_d <= req_data[i*DATA_W +: DATA_W];
      end else if (w_grant[i]) r_v <= 1'b0;
    assign w_valid[i] = r_v;
    assign w_tag[i]   = r_t;
    assign w_addr[i]  = r_a;
    assign w_data[i]  = r_d;
  end

  always_comb begin
    w_sel_tag  = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sel_tag  = w_sel_tag  | (w_grant[k] ? w_tag[k]  : '0);
      w_sel_addr = w_sel_addr | (w_grant[k] ? w_addr[k] : '0);
      w_sel_data = w_sel_data | (w_grant[k] ? w_data[k] : '0);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_addr  <= '0;
      cdb_data  <= '0;
    end else begin
      cdb_valid <= |w_grant;
      cdb_tag   <= w_sel_tag;
      cdb_addr  <= w_sel_addr;
      cdb_data  <= w_sel_data;
    end

`ifdef CDB_RR_EN
  logic [PW-1:0] r_ptr, w_gidx;
  always_comb begin
    w_gidx = '0;
    for (int k = 0; k < N_REQ; k++) w_gidx = w_grant[k] ? PW'(k) : w_gidx;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= '0;
    else if (|w_grant) r_ptr <= (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: vector table, hand sequences and random traffic against a slot-level reference model.
module tb_cdb_arbiter;
  import cdb_pkg::*;
  localparam int N = N_REQ;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*TAG_W-1:0]  req_tag  = '0;
  logic [N*ADDR_W-1:0] req_addr = '0;
  logic [N*DATA_W-1:0] req_data = '0;
  logic cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [ADDR_W-1:0] cdb_addr;
  logic [DATA_W-1:0] cdb_data;
  logic [3:0] pending_cnt;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_addr(cdb_addr), .cdb_data(cdb_data), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [TAG_W-1:0]  t_tag[N];
  logic [ADDR_W-1:0] t_addr[N];
  logic [DATA_W-1:0] t_data[N];
  bit                m_v[N];
  logic [TAG_W-1:0]  m_t[N];
  logic [ADDR_W-1:0] m_a[N];
  logic [DATA_W-1:0] m_d[N];
  int m_ptr;
  logic m_cv;
  logic [TAG_W-1:0]  m_ct;
  logic [ADDR_W-1:0] m_ca;
  logic [DATA_W-1:0] m_cd;
  logic [N-1:0] s_ready;

  typedef struct {
    logic fl;
    logic [8:0] vld, ztag, rdy;
    logic cv;
    logic [3:0] tg;
    logic [31:0] dt;
    logic [3:0] pn;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_v[i] = 0;
    m_ptr = 0;
    m_cv = 0; m_ct = '0; m_ca = '0; m_cd = '0;
  endtask

  function automatic int model_pending();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_v[i]);
    return c;
  endfunction

  task automatic cycle();
    int g;
    logic [N-1:0] er;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TAG_W +: TAG_W]    = t_tag[i];
      req_addr[i*ADDR_W +: ADDR_W] = t_addr[i];
      req_data[i*DATA_W +: DATA_W] = t_data[i];
    end
    @(negedge clk);
    g = -1;
    if (!flush)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) er[i] = !m_v[i] || i == g || flush;
    s_ready = req_ready;
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    if (g >= 0) begin
      m_cv = 1; m_ct = m_t[g]; m_ca = m_a[g]; m_cd = m_d[g];
      m_v[g] = 0;
`ifdef CDB_RR_EN
      m_ptr = (g + 1) % N;
`endif
    end else begin
      m_cv = 0; m_ct = '0; m_ca = '0; m_cd = '0;
    end
    for (int i = 0; i < N; i++)
      if (flush) m_v[i] = 0;
      else if (req_valid[i] && er[i] && t_tag[i] != 0) begin
        m_v[i] = 1; m_t[i] = t_tag[i]; m_a[i] = t_addr[i]; m_d[i] = t_data[i];
      end
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_cv));
    chk("cdb_tag", 64'(cdb_tag), 64'(m_ct));
    chk("cdb_addr", 64'(cdb_addr), 64'(m_ca));
    chk("cdb_data", 64'(cdb_data), 64'(m_cd));
    chk("pending_cnt", 64'(pending_cnt), 64'(model_pending()));
  endtask

  task automatic set_std(input logic [8:0] vld, input logic [8:0] ztag);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = vld[i];
      t_tag[i]  = ztag[i] ? '0 : TAG_W'(i + 1);
      t_addr[i] = ADDR_W'(i + 16);
      t_data[i] = DATA_W'((i + 1) * 'h11);
    end
  endtask

  initial begin
    int prev;
    tbl[0] = '{1'b0, 9'h000, 9'h000, 9'h1FF, 1'b0, 4'd0, 32'h00, 4'd0};
    tbl[1] = '{1'b0, 9'h041, 9'h000, 9'h1FF, 1'b0, 4'd0, 32'h00, 4'd2};
    tbl[2] = '{1'b0, 9'h000, 9'h000, 9'h1BF, 1'b1, 4'd1, 32'h11, 4'd1};
    tbl[3] = '{1'b0, 9'h000, 9'h000, 9'h1FF, 1'b1, 4'd7, 32'h77, 4'd0};
    tbl[4] = '{1'b0, 9'h000, 9'h000, 9'h1FF, 1'b0, 4'd0, 32'h00, 4'd0};
    tbl[5] = '{1'b0, 9'h100, 9'h100, 9'h1FF, 1'b0, 4'd0, 32'h00, 4'd0};
    tbl[6] = '{1'b0, 9'h000, 9'h000, 9'h1FF, 1'b0, 4'd0, 32'h00, 4'd0};
    tbl[7] = '{1'b0, 9'h01E, 9'h000, 9'h1FF, 1'b0, 4'd0, 32'h00, 4'd4};
    tbl[8] = '{1'b1, 9'h020, 9'h000, 9'h1FF, 1'b0, 4'd0, 32'h00, 4'd0};
    tbl[9] = '{1'b0, 9'h000, 9'h000, 9'h1FF, 1'b0, 4'd0, 32'h00, 4'd0};
    model_reset();
    set_std(9'h000, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset cdb_valid", 64'(cdb_valid), 64'(0));
    chk("reset pending", 64'(pending_cnt), 64'(0));
    chk("reset ready", 64'(req_ready), 64'(9'h1FF));
    @(negedge clk) rst = 1'b0;

    for (int r = 0; r < 10; r++) begin
      flush = tbl[r].fl;
      set_std(tbl[r].vld, tbl[r].ztag);
      cycle();
      chk($sformatf("tbl%0d ready", r), 64'(s_ready), 64'(tbl[r].rdy));
      chk($sformatf("tbl%0d cv", r), 64'(cdb_valid), 64'(tbl[r].cv));
      chk($sformatf("tbl%0d tag", r), 64'(cdb_tag), 64'(tbl[r].tg));
      chk($sformatf("tbl%0d data", r), 64'(cdb_data), 64'(tbl[r].dt));
      chk($sformatf("tbl%0d pend", r), 64'(pending_cnt), 64'(tbl[r].pn));
    end
    flush = 1'b0;

    set_std(9'h008, 9'h000);
    t_data[REQ_MUL1] = 32'h1234;
    cycle();
    t_data[REQ_MUL1] = 32'hABCD;
    cycle();
    chk("refill ready3", 64'(s_ready[REQ_MUL1]), 64'(1));
    chk("refill old data", 64'(cdb_data), 64'(32'h1234));
    req_valid = '0;
    cycle();
    chk("refill new cv", 64'(cdb_valid), 64'(1));
    chk("refill new data", 64'(cdb_data), 64'(32'hABCD));
    cycle();
    chk("refill once", 64'(cdb_valid), 64'(0));

    set_std(9'h0F0, 9'h000);
    cycle();
    req_valid = '0;
    cycle();
    chk("pre-reset pend", 64'(pending_cnt), 64'(3));
    #2 rst = 1'b1;
    #1;
    chk("async rst cv", 64'(cdb_valid), 64'(0));
    chk("async rst pend", 64'(pending_cnt), 64'(0));
    chk("async rst tag", 64'(cdb_tag), 64'(0));
    chk("async rst data", 64'(cdb_data), 64'(0));
    model_reset();
    @(negedge clk) rst = 1'b0;
    repeat (3) cycle();

`ifdef CDB_RR_EN
    set_std(9'h1FF, 9'h000);
    prev = -1;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (cdb_valid && prev >= 0) chk("rr order", 64'(cdb_tag), 64'(prev % N + 1));
      prev = cdb_valid ? int'(cdb_tag) : -1;
    end
`endif

    for (int c = 0; c < 2000; c++) begin
      flush = ($urandom_range(0, 19) == 0);
      req_valid = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        t_tag[i]  = ($urandom_range(0, 4) == 0) ? '0 : TAG_W'($urandom_range(1, 15));
        t_addr[i] = ADDR_W'($urandom);
        t_data[i] = $urandom;
      end
      cycle();
    end
    flush = 1'b0;
    req_valid = '0;
    repeat (12) cycle();
    chk("drained pend", 64'(pending_cnt), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
